// File: rtl/text_tile_gen_pkg.sv
// Shared constants for the text-mode tile renderer: glyph geometry,
// character-cell field layout and the fixed colours.
package text_tile_gen_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  // Cell word layout: {blink, fg[2:0], char[6:0]}
  localparam int CELL_W    = 11;
  localparam int BLINK_BIT = 10;
  localparam int FG_MSB    = 9;
  localparam int FG_LSB    = 7;
  localparam int CHAR_MSB  = 6;
  localparam int CHAR_LSB  = 0;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;

endpackage

// File: rtl/text_tile_gen_cell_ram.sv
// Character buffer: one write port, one synchronous read port.
// A read of the cell being written in the same cycle returns the old word.
module text_cell_ram #(
  parameter int DEPTH  = 2400,
  parameter int WIDTH  = 11,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  // Write and registered read; NBA ordering gives read-old on collision.
  always_ff @(posedge clk) begin
    if (we) mem[waddr[AW-1:0]] <= wdata;
    rdata <= mem[raddr[AW-1:0]];
  end

endmodule

// File: rtl/text_tile_gen.sv
// Text-mode renderer: maps the pixel position to a character cell, reads
// the cell from the buffer, fetches the glyph row from the external font ROM
// and produces the registered pixel colour three clocks after the inputs.
module text_tile_gen
  import text_tile_gen_pkg::*;
#(
  parameter int CHAR_COLS     = 80,
  parameter int CHAR_ROWS     = 30,
  parameter int SCALE_LOG2    = 0,
  parameter int BLINK_FRAMES  = 32,
  parameter int WR_BLANK_ONLY = 1,
  parameter int ADDR_W        = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              frame_tick,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [10:0]       wr_data,
  output logic              wr_ready,
  input  logic [2:0]        bg_color,
  input  logic              cursor_en,
  input  logic [6:0]        cursor_col,
  input  logic [4:0]        cursor_row,
  output logic [10:0]       rom_addr,
  input  logic [7:0]        rom_data,
  output logic [2:0]        rgb_text
);

  localparam int NCELLS = CHAR_COLS * CHAR_ROWS;
  localparam int COL_SH = $clog2(GLYPH_W) + SCALE_LOG2;
  localparam int ROW_SH = $clog2(GLYPH_H) + SCALE_LOG2;
  localparam int BCNT_W = $clog2(BLINK_FRAMES);

  function automatic logic [2:0] pix_color(
    input logic       von,
    input logic       in_area,
    input logic       pix,
    input logic       blink,
    input logic       phase,
    input logic       cur_hit,
    input logic [2:0] fg,
    input logic [2:0] bg
  );
    logic on;
    if (!von) return BLACK;
    if (!in_area) return bg;
    on = pix & ~(blink & ~phase);
    if (cur_hit & phase) on = ~on;
    return on ? fg : bg;
  endfunction

  logic [9:0]        col, row;
  logic [3:0]        glyph_row;
  logic [2:0]        bit_idx;
  logic              in_area, cursor_hit, wr_commit;
  logic [ADDR_W-1:0] cell_idx, rd_addr;
  logic [CELL_W-1:0] cell_q;

  assign col        = pixel_x >> COL_SH;
  assign row        = pixel_y >> ROW_SH;
  assign glyph_row  = 4'(pixel_y >> SCALE_LOG2);
  assign bit_idx    = 3'(pixel_x >> SCALE_LOG2);
  assign cell_idx   = ADDR_W'(row) * ADDR_W'(CHAR_COLS) + ADDR_W'(col);
  assign in_area    = (col < 10'(CHAR_COLS)) && (row < 10'(CHAR_ROWS));
  assign cursor_hit = cursor_en && (col == {3'b000, cursor_col}) && (row == {5'b00000, cursor_row});
  // Off-screen positions read cell 0; their colour ignores the word anyway.
  assign rd_addr    = in_area ? cell_idx : '0;

  assign wr_ready  = (WR_BLANK_ONLY != 0) ? ~video_on : 1'b1;
  // Addresses past the last cell are acknowledged but dropped.
  assign wr_commit = wr_en && wr_ready && ({1'b0, wr_addr} < (ADDR_W+1)'(NCELLS));

  text_cell_ram #(
    .DEPTH (NCELLS),
    .WIDTH (CELL_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_commit),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(cell_q)
  );

  logic [BCNT_W-1:0] blink_cnt;
  logic              blink_phase;

  // Frame counter toggling the blink phase every BLINK_FRAMES ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BCNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // ---- stage p0: buffer read issued, sideband captured ----
  logic       vld_p0, von_p0, area_p0, cur_p0;
  logic [3:0] grow_p0;
  logic [2:0] bit_p0;

  // Sideband registers aligned with the buffer read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      von_p0  <= 1'b0;
      area_p0 <= 1'b0;
      cur_p0  <= 1'b0;
      grow_p0 <= '0;
      bit_p0  <= '0;
    end else begin
      vld_p0  <= 1'b1;
      von_p0  <= video_on;
      area_p0 <= in_area;
      cur_p0  <= cursor_hit;
      grow_p0 <= glyph_row;
      bit_p0  <= bit_idx;
    end
  end

  // Glyph fetch address goes straight from the buffer word to the ROM.
  assign rom_addr = vld_p0 ? {cell_q[CHAR_MSB:CHAR_LSB], grow_p0} : '0;

  // ---- stage p1: ROM access in flight, cell attributes carried ----
  logic       vld_p1, von_p1, area_p1, cur_p1, blink_p1;
  logic [2:0] bit_p1, fg_p1;

  // Control sideband aligned with the ROM access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      von_p1  <= 1'b0;
      area_p1 <= 1'b0;
      cur_p1  <= 1'b0;
      bit_p1  <= '0;
    end else begin
      vld_p1  <= vld_p0;
      von_p1  <= von_p0;
      area_p1 <= area_p0;
      cur_p1  <= cur_p0;
      bit_p1  <= bit_p0;
    end
  end

  // Cell attributes carried alongside the ROM access.
  always_ff @(posedge clk) begin
    fg_p1    <= cell_q[FG_MSB:FG_LSB];
    blink_p1 <= cell_q[BLINK_BIT];
  end

  // ---- output stage: glyph bit selected, colour registered ----
  logic [2:0] pix_sel;
  assign pix_sel = 3'd7 - bit_p1;

  // Final colour; an empty pipe after reset yields black.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_text <= BLACK;
    end else if (vld_p1) begin
      rgb_text <= pix_color(von_p1, area_p1, rom_data[pix_sel], blink_p1,
                            blink_phase, cur_p1, fg_p1, bg_color);
    end else begin
      rgb_text <= BLACK;
    end
  end

endmodule

// File: tb/tb_text_tile_gen.sv
// Randomised bench for text_tile_gen: two instances (1x and 2x scale) share
// stimulus; expected colours come from a cell/pixel model of the screen.
module tb_text_tile_gen;
  import text_tile_gen_pkg::*;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int NCELL = COLS * ROWS;
  localparam int BF    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        frame_tick = 1'b0;
  logic        wr_en = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [10:0] wr_data = '0;
  logic [2:0]  bg_color = '0;
  logic        cursor_en = 1'b0;
  logic [6:0]  cursor_col = '0;
  logic [4:0]  cursor_row = '0;

  logic        wr_ready0, wr_ready1;
  logic [10:0] rom_addr0, rom_addr1;
  logic [7:0]  rom_data0, rom_data1;
  logic [2:0]  rgb0, rgb1;

  logic [10:0] mem_m [NCELL];
  int          ticks;
  logic [2:0]  q0[$], q1[$];
  int          tests, fails;

  always #5 clk = ~clk;

  text_tile_gen #(.CHAR_COLS(COLS), .CHAR_ROWS(ROWS), .SCALE_LOG2(0), .BLINK_FRAMES(BF),
                  .WR_BLANK_ONLY(1), .ADDR_W(12)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_tick(frame_tick), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready0), .bg_color(bg_color), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .rom_addr(rom_addr0),
    .rom_data(rom_data0), .rgb_text(rgb0));

  text_tile_gen #(.CHAR_COLS(COLS), .CHAR_ROWS(ROWS), .SCALE_LOG2(1), .BLINK_FRAMES(BF),
                  .WR_BLANK_ONLY(1), .ADDR_W(12)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_tick(frame_tick), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready1), .bg_color(bg_color), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .rom_addr(rom_addr1),
    .rom_data(rom_data1), .rgb_text(rgb1));

  // Font contents: space is blank, every other glyph is a fixed pseudo-pattern.
  function automatic logic [7:0] font(input logic [6:0] ch, input logic [3:0] r);
    int v;
    if (ch == 7'h20) return 8'h00;
    v = int'(ch) * 29 + int'(r) * 53 + (int'(ch) ^ int'(r)) * 7;
    return v[7:0];
  endfunction

  // Synchronous font ROMs, one per instance.
  always @(posedge clk) begin
    rom_data0 <= font(rom_addr0[10:4], rom_addr0[3:0]);
    rom_data1 <= font(rom_addr1[10:4], rom_addr1[3:0]);
  end

  // Colour the screen should show at (x,y) for magnification 2^sl.
  function automatic logic [2:0] exp_color(input int sl, input int x, input int y, input bit von);
    int s, col, row, gr, bi;
    logic [10:0] c;
    logic [7:0]  g;
    bit on, phase;
    s = 1 << sl;
    col = x / (8 * s);
    row = y / (16 * s);
    phase = ((ticks / BF) % 2) == 1;
    if (!von) return BLACK;
    if (col >= COLS || row >= ROWS) return bg_color;
    c  = mem_m[row * COLS + col];
    gr = (y / s) % 16;
    bi = (x / s) % 8;
    g  = font(c[6:0], 4'(gr));
    on = g[7 - bi];
    if (c[10] && !phase) on = 1'b0;
    if (cursor_en && col == int'(cursor_col) && row == int'(cursor_row) && phase) on = !on;
    return on ? c[9:7] : bg_color;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pixel clock: drive inputs, record expectation, check the pixel from 3 clocks ago.
  task automatic step(input int x, input int y, input bit von);
    logic [2:0] e;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    q0.push_back(exp_color(0, x, y, von));
    q1.push_back(exp_color(1, x, y, von));
    if (wr_en && !von && int'(wr_addr) < NCELL) mem_m[wr_addr] = wr_data;
    if (frame_tick) ticks++;
    @(negedge clk);
    if (wr_en) begin
      chk("wr_ready0", 16'(wr_ready0), 16'(!von));
      chk("wr_ready1", 16'(wr_ready1), 16'(!von));
    end
    if (q0.size() > 3) begin
      e = q0.pop_front();
      chk("rgb_x1", 16'(rgb0), 16'(e));
      e = q1.pop_front();
      chk("rgb_x2", 16'(rgb1), 16'(e));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    repeat (3) step(0, 0, 1'b0);
  endtask

  task automatic tick();
    flush();
    frame_tick = 1'b1;
    step(0, 0, 1'b0);
    frame_tick = 1'b0;
  endtask

  task automatic scan_cell(input int col, input int row);
    for (int gy = 0; gy < 16; gy++)
      for (int gx = 0; gx < 8; gx++)
        step(col * 8 + gx, row * 16 + gy, 1'b1);
  endtask

  task automatic prime_after_reset();
    repeat (3) begin
      q0.push_back(BLACK);
      q1.push_back(BLACK);
    end
  endtask

  task automatic random_scan(input int n);
    int x, y;
    for (int i = 0; i < n; i++) begin
      x = ($urandom % 4 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 639));
      y = ($urandom % 4 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 479));
      step(x, y, ($urandom % 8) != 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    tests = 0;
    fails = 0;
    ticks = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rgb_x1", 16'(rgb0), 16'(BLACK));
    chk("reset_rgb_x2", 16'(rgb1), 16'(BLACK));
    chk("reset_rom_addr_x1", 16'(rom_addr0), 16'h0);
    chk("reset_rom_addr_x2", 16'(rom_addr1), 16'h0);
    rst_n = 1'b1;
    prime_after_reset();

    // Fill the whole buffer during blank
    for (int i = 0; i < NCELL; i++) begin
      d = $urandom;
      wr_en   = 1'b1;
      wr_addr = 12'(i);
      wr_data = {d[0] & d[1] & d[2], d[5:3], d[12:6]};
      if (i == 0)   wr_data = {1'b0, 3'b010, 7'h41};
      if (i == 5)   wr_data = {1'b1, 3'b110, 7'h42};
      if (i == 163) wr_data = {1'b0, 3'b011, 7'h20};
      step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0);
    end
    wr_en = 1'b0;

    // Scan text row 0
    bg_color = 3'b001;
    for (int x = 0; x < 640; x++) step(x, int'($urandom_range(0, 15)), 1'b1);
    flush();

    // Random pixels with the cursor enabled (phase 0)
    bg_color   = WHITE;
    cursor_en  = 1'b1;
    cursor_col = 7'd3;
    cursor_row = 5'd2;
    random_scan(1500);
    flush();

    // Write during active video is refused
    wr_en   = 1'b1;
    wr_addr = 12'd0;
    wr_data = 11'h7FF;
    step(8, 0, 1'b1);
    wr_en = 1'b0;
    scan_cell(0, 0);

    // Same write during blank lands
    wr_en   = 1'b1;
    wr_addr = 12'd0;
    wr_data = {1'b0, 3'b101, 7'h33};
    step(0, 0, 1'b0);
    wr_en = 1'b0;
    scan_cell(0, 0);

    // Blink and cursor over 8 frames
    flush();
    bg_color = 3'b100;
    for (int t = 0; t < 8; t++) begin
      tick();
      scan_cell(5, 0);
      scan_cell(3, 2);
    end

    // Out-of-range writes are dropped without aliasing
    flush();
    foreach (d[i]) if (i < 3) begin
      wr_en   = 1'b1;
      wr_addr = (i == 0) ? 12'd2400 : (i == 1) ? 12'd3000 : 12'd4095;
      wr_data = 11'h5AA;
      step(0, 0, 1'b0);
    end
    wr_en = 1'b0;
    random_scan(600);

    // Reset mid-line
    flush();
    bg_color = 3'b110;
    for (int gx = 0; gx < 8; gx++) step(gx, 3, 1'b1);
    pixel_x = 10'd4;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_rgb_x1", 16'(rgb0), 16'(BLACK));
    chk("async_reset_rgb_x2", 16'(rgb1), 16'(BLACK));
    chk("async_reset_rom_addr_x1", 16'(rom_addr0), 16'h0);
    chk("async_reset_rom_addr_x2", 16'(rom_addr1), 16'h0);
    q0.delete();
    q1.delete();
    ticks = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    prime_after_reset();
    scan_cell(0, 0);
    random_scan(600);
    flush();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
